// File: rtl/input_mem_read_arbiter_if.sv
// Bundle of the two client read ports and the shared input-memory read port
// seen by input_mem_read_arbiter.
//   slave  : arbiter view (takes client requests and memory returns)
//   master : environment view (clients and memory buffer)
interface input_mem_read_arbiter_if #(
  parameter int INMEM_BYTE_WIDTH    = 1,
  parameter int INMEM_ADDRESS_WIDTH = 17
);
  // client 0 read port
  logic                             c0ReadReq;
  logic                             c0ReadAck;
  logic [INMEM_ADDRESS_WIDTH-1:0]   c0ReadAdd;
  logic                             c0ReadDataValid;
  // client 1 read port
  logic                             c1ReadReq;
  logic                             c1ReadAck;
  logic [INMEM_ADDRESS_WIDTH-1:0]   c1ReadAdd;
  logic                             c1ReadDataValid;
  // return data shared by both clients
  logic [INMEM_BYTE_WIDTH*8-1:0]    clientReadData;
  // input-memory read port
  logic                             inputMemoryReadReq;
  logic                             inputMemoryReadAck;
  logic [INMEM_ADDRESS_WIDTH-1:0]   inputMemoryReadAdd;
  logic                             inputMemoryReadDataValid;
  logic [INMEM_BYTE_WIDTH*8-1:0]    inputMemoryReadData;
  // sticky error flag
  logic                             protocolError;

  modport slave (
    input  c0ReadReq, c0ReadAdd, c1ReadReq, c1ReadAdd,
    input  inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData,
    output c0ReadAck, c0ReadDataValid, c1ReadAck, c1ReadDataValid, clientReadData,
    output inputMemoryReadReq, inputMemoryReadAdd, protocolError
  );

  modport master (
    output c0ReadReq, c0ReadAdd, c1ReadReq, c1ReadAdd,
    output inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData,
    input  c0ReadAck, c0ReadDataValid, c1ReadAck, c1ReadDataValid, clientReadData,
    input  inputMemoryReadReq, inputMemoryReadAdd, protocolError
  );
endinterface

// File: rtl/input_mem_read_arbiter.sv
// input_mem_read_arbiter
// Shares one input-memory read port between two compute clients. Requests are
// arbitrated round-robin and passed straight through to memory (no added
// latency); every accepted read records its client id in a small in-order tag
// FIFO so returning data can be steered back to the right client.
// Optional feature macro: INARB_GRANT_COUNT_EN adds saturating 16-bit
// per-client accept counters (c0GrantCount / c1GrantCount).
module input_mem_read_arbiter #(
  parameter int INMEM_BYTE_WIDTH    = 1,
  parameter int INMEM_ADDRESS_WIDTH = 17,
  parameter int TAG_DEPTH           = 4
) (
  input  logic                      clk,
  input  logic                      resetN,
  input_mem_read_arbiter_if.slave   bus
`ifdef INARB_GRANT_COUNT_EN
  ,
  output logic [15:0]               c0GrantCount,
  output logic [15:0]               c1GrantCount
`endif
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(TAG_DEPTH);

  // arbitration / tag state
  logic                            lastGrant;
  logic [TAG_DEPTH-1:0]            tagMem;
  logic [PTR_W-1:0]                wrPtr;
  logic [PTR_W-1:0]                rdPtr;
  logic [CNT_W-1:0]                count;
  logic                            protocolErrorR;

  // combinational helpers
  logic                            selected;
  logic                            selReq;
  logic [INMEM_ADDRESS_WIDTH-1:0]  selAdd;
  logic                            full;
  logic                            memReq;
  logic                            accept;
  logic                            returnSeen;
  logic                            pop;
  logic                            badReturn;
  logic                            headId;

  // Round-robin select: a lone requester wins, otherwise the client not granted last
  always_comb begin
    selected = ~lastGrant;
    if (bus.c0ReadReq && !bus.c1ReadReq) begin
      selected = 1'b0;
    end else if (!bus.c0ReadReq && bus.c1ReadReq) begin
      selected = 1'b1;
    end else begin
      selected = ~lastGrant;
    end
  end

  // Request path mux, full gating and accept/return decode
  always_comb begin
    selReq     = selected ? bus.c1ReadReq : bus.c0ReadReq;
    selAdd     = selected ? bus.c1ReadAdd : bus.c0ReadAdd;
    full       = (count == FULL_COUNT);
    // outputs held low while reset is asserted, independent of the clock
    memReq     = resetN & selReq & ~full;
    accept     = memReq & bus.inputMemoryReadAck;
    returnSeen = resetN & bus.inputMemoryReadDataValid;
    pop        = returnSeen & (count != {CNT_W{1'b0}});
    badReturn  = returnSeen & (count == {CNT_W{1'b0}});
    headId     = tagMem[rdPtr];
  end

  assign bus.inputMemoryReadReq = memReq;
  assign bus.inputMemoryReadAdd = selAdd;
  assign bus.c0ReadAck          = accept & ~selected;
  assign bus.c1ReadAck          = accept & selected;
  assign bus.c0ReadDataValid    = pop & ~headId;
  assign bus.c1ReadDataValid    = pop & headId;
  assign bus.clientReadData     = bus.inputMemoryReadData;
  assign bus.protocolError      = protocolErrorR;

  // Grant history: remember who won the last accepted read
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lastGrant <= 1'b1;
    end else if (accept) begin
      lastGrant <= selected;
    end else begin
      lastGrant <= lastGrant;
    end
  end

  // Tag FIFO storage and pointers: push on accept, pop on a valid return
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tagMem <= {TAG_DEPTH{1'b0}};
      wrPtr  <= {PTR_W{1'b0}};
      rdPtr  <= {PTR_W{1'b0}};
    end else begin
      if (accept) begin
        tagMem[wrPtr] <= selected;
        wrPtr         <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
    end
  end

  // Outstanding-read count; push and pop in the same cycle cancel out
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= {CNT_W{1'b0}};
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for data returned while nothing is outstanding
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      protocolErrorR <= 1'b0;
    end else begin
      protocolErrorR <= protocolErrorR | badReturn;
    end
  end

`ifdef INARB_GRANT_COUNT_EN
  // Per-client saturating accept counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      c0GrantCount <= 16'd0;
      c1GrantCount <= 16'd0;
    end else begin
      if (accept && !selected && (c0GrantCount != 16'hFFFF)) begin
        c0GrantCount <= c0GrantCount + 16'd1;
      end
      if (accept && selected && (c1GrantCount != 16'hFFFF)) begin
        c1GrantCount <= c1GrantCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_input_mem_read_arbiter.sv
// Scoreboard bench for input_mem_read_arbiter: the driver pushes expected acks
// and returns into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_input_mem_read_arbiter;
  localparam int BW = 1;
  localparam int AW = 17;
  localparam int TD = 4;

  typedef struct packed { logic client; logic [AW-1:0] addr; } ackExp_t;
  typedef struct packed { logic client; logic [7:0] data; } retExp_t;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  input_mem_read_arbiter_if #(.INMEM_BYTE_WIDTH(BW), .INMEM_ADDRESS_WIDTH(AW)) bus();
`ifdef INARB_GRANT_COUNT_EN
  logic [15:0] c0GrantCount;
  logic [15:0] c1GrantCount;
`endif

  input_mem_read_arbiter #(
    .INMEM_BYTE_WIDTH(BW), .INMEM_ADDRESS_WIDTH(AW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
`ifdef INARB_GRANT_COUNT_EN
    ,
    .c0GrantCount(c0GrantCount),
    .c1GrantCount(c1GrantCount)
`endif
  );

  ackExp_t ackQ[$];
  retExp_t retQ[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic pushAck(logic c, logic [AW-1:0] a);
    ackExp_t e;
    e.client = c;
    e.addr = a;
    ackQ.push_back(e);
  endtask

  task automatic pushRet(logic c, logic [7:0] d);
    retExp_t e;
    e.client = c;
    e.data = d;
    retQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.c0ReadReq = 1'b0;
    bus.c1ReadReq = 1'b0;
    bus.c0ReadAdd = '0;
    bus.c1ReadAdd = '0;
    bus.inputMemoryReadAck = 1'b0;
    bus.inputMemoryReadDataValid = 1'b0;
    bus.inputMemoryReadData = 8'h00;
  endtask

  task automatic doReset();
    idle();
    resetN = 1'b0;
    #1;
    check("reset protocolError", {31'd0, bus.protocolError}, 32'd0);
    step();
    step();
    resetN = 1'b1;
  endtask

  // Monitor: compare every ack and every returned datum against the queues
  always @(negedge clk) begin
    if (bus.c0ReadAck || bus.c1ReadAck) begin
      if (ackQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected ack: got c0=%0b c1=%0b expected none", bus.c0ReadAck, bus.c1ReadAck);
      end else begin
        ackExp_t e;
        e = ackQ.pop_front();
        check("ack client", {30'd0, bus.c1ReadAck, bus.c0ReadAck}, e.client ? 32'd2 : 32'd1);
        check("ack address", {15'd0, bus.inputMemoryReadAdd}, {15'd0, e.addr});
      end
    end
    if (bus.c0ReadDataValid || bus.c1ReadDataValid) begin
      if (retQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected valid: got c0=%0b c1=%0b expected none", bus.c0ReadDataValid, bus.c1ReadDataValid);
      end else begin
        retExp_t e;
        e = retQ.pop_front();
        check("valid client", {30'd0, bus.c1ReadDataValid, bus.c0ReadDataValid}, e.client ? 32'd2 : 32'd1);
        check("return data", {24'd0, bus.clientReadData}, {24'd0, e.data});
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic prevClient;
    idle();
    resetN = 1'b0;
    #1;
    // reset state
    check("reset memReq", {31'd0, bus.inputMemoryReadReq}, 32'd0);
    check("reset acks", {30'd0, bus.c1ReadAck, bus.c0ReadAck}, 32'd0);
    check("reset valids", {30'd0, bus.c1ReadDataValid, bus.c0ReadDataValid}, 32'd0);
    check("reset address", {15'd0, bus.inputMemoryReadAdd}, 32'd0);
    check("reset protocolError", {31'd0, bus.protocolError}, 32'd0);
    step();
    step();
    resetN = 1'b1;

    // 1: single c0 read, data back two cycles after accept
    bus.c0ReadReq = 1'b1;
    bus.c0ReadAdd = 17'd5;
    bus.inputMemoryReadAck = 1'b1;
    pushAck(1'b0, 17'd5);
    #2;
    check("t1 memReq", {31'd0, bus.inputMemoryReadReq}, 32'd1);
    step();
    idle();
    bus.inputMemoryReadAck = 1'b1;
    step();
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 8'hA5;
    pushRet(1'b0, 8'hA5);
    step();
    idle();
    step();
    check("t1 drained", ackQ.size() + retQ.size(), 32'd0);

    // 2: both clients requesting, data back one cycle after accept
    doReset();
    for (int i = 0; i <= 8; i++) begin
      bus.c0ReadReq = (i < 8);
      bus.c1ReadReq = (i < 8);
      bus.c0ReadAdd = 17'h100 + 17'(i);
      bus.c1ReadAdd = 17'h200 + 17'(i);
      bus.inputMemoryReadAck = 1'b1;
      if (i < 8) pushAck(1'(i % 2), (i % 2 == 1) ? 17'h200 + 17'(i) : 17'h100 + 17'(i));
      bus.inputMemoryReadDataValid = (i >= 1);
      bus.inputMemoryReadData = 8'h30 + 8'(i);
      if (i >= 1) pushRet(1'((i - 1) % 2), 8'h30 + 8'(i));
      step();
    end
    idle();
    step();
    check("t2 drained", ackQ.size() + retQ.size(), 32'd0);

    // 3: memory withholds data: exactly TAG_DEPTH accepts, then blocked
    doReset();
    bus.c0ReadReq = 1'b1;
    bus.c0ReadAdd = 17'h0AAAA;
    bus.inputMemoryReadAck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < TD) pushAck(1'b0, 17'h0AAAA);
      #2;
      check("t3 memReq", {31'd0, bus.inputMemoryReadReq}, (i < TD) ? 32'd1 : 32'd0);
      step();
    end
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 8'h77;
    pushRet(1'b0, 8'h77);
    #2;
    check("t3 full with pop memReq", {31'd0, bus.inputMemoryReadReq}, 32'd0);
    step();
    bus.inputMemoryReadDataValid = 1'b0;
    pushAck(1'b0, 17'h0AAAA);
    #2;
    check("t3 after pop memReq", {31'd0, bus.inputMemoryReadReq}, 32'd1);
    step();
    #2;
    check("t3 full again memReq", {31'd0, bus.inputMemoryReadReq}, 32'd0);
    idle();
    step();
    check("t3 drained", ackQ.size() + retQ.size(), 32'd0);

    // 4: return with nothing outstanding
    doReset();
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 8'h5A;
    #2;
    check("t4 protocolError before edge", {31'd0, bus.protocolError}, 32'd0);
    step();
    bus.inputMemoryReadDataValid = 1'b0;
    #2;
    check("t4 protocolError set", {31'd0, bus.protocolError}, 32'd1);
    step();
    step();
    step();
    check("t4 protocolError sticky", {31'd0, bus.protocolError}, 32'd1);

    // 5: reset with three reads outstanding
    doReset();
    bus.c0ReadReq = 1'b1;
    bus.c1ReadReq = 1'b1;
    bus.c0ReadAdd = 17'h11;
    bus.c1ReadAdd = 17'h22;
    bus.inputMemoryReadAck = 1'b1;
    pushAck(1'b0, 17'h11);
    pushAck(1'b1, 17'h22);
    pushAck(1'b0, 17'h11);
    step();
    step();
    step();
    idle();
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 8'hEE;
    resetN = 1'b0;
    #1;
    check("t5 async memReq", {31'd0, bus.inputMemoryReadReq}, 32'd0);
    check("t5 async acks", {30'd0, bus.c1ReadAck, bus.c0ReadAck}, 32'd0);
    check("t5 async valids", {30'd0, bus.c1ReadDataValid, bus.c0ReadDataValid}, 32'd0);
    check("t5 async address", {15'd0, bus.inputMemoryReadAdd}, 32'd0);
    step();
    step();
    bus.inputMemoryReadDataValid = 1'b0;
    resetN = 1'b1;
    bus.c0ReadReq = 1'b1;
    bus.c1ReadReq = 1'b1;
    bus.c0ReadAdd = 17'h33;
    bus.c1ReadAdd = 17'h44;
    bus.inputMemoryReadAck = 1'b1;
    pushAck(1'b0, 17'h33);
    step();
    idle();
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 8'hC3;
    pushRet(1'b0, 8'hC3);
    step();
    bus.inputMemoryReadData = 8'h3C;
    #2;
    check("t5 one tag after reset", {31'd0, bus.protocolError}, 32'd0);
    step();
    bus.inputMemoryReadDataValid = 1'b0;
    #2;
    check("t5 stale tags flushed", {31'd0, bus.protocolError}, 32'd1);
    step();
    check("t5 drained", ackQ.size() + retQ.size(), 32'd0);

`ifdef INARB_GRANT_COUNT_EN
    // 6: grant counters, then saturation
    doReset();
    check("t6 reset c0GrantCount", {16'd0, c0GrantCount}, 32'd0);
    check("t6 reset c1GrantCount", {16'd0, c1GrantCount}, 32'd0);
    prevClient = 1'b0;
    for (int i = 0; i <= 17; i++) begin
      logic c;
      c = (i < 14) ? 1'(i % 2) : 1'b0;
      bus.c0ReadReq = (i < 17);
      bus.c1ReadReq = (i < 14);
      bus.c0ReadAdd = 17'h1;
      bus.c1ReadAdd = 17'h2;
      bus.inputMemoryReadAck = 1'b1;
      if (i < 17) pushAck(c, c ? 17'h2 : 17'h1);
      bus.inputMemoryReadDataValid = (i >= 1);
      bus.inputMemoryReadData = 8'(i);
      if (i >= 1) pushRet(prevClient, 8'(i));
      prevClient = c;
      step();
    end
    idle();
    check("t6 c0GrantCount", {16'd0, c0GrantCount}, 32'd10);
    check("t6 c1GrantCount", {16'd0, c1GrantCount}, 32'd7);
    doReset();
    for (int i = 0; i <= 65540; i++) begin
      bus.c0ReadReq = (i < 65540);
      bus.c0ReadAdd = 17'h7;
      bus.inputMemoryReadAck = 1'b1;
      if (i < 65540) pushAck(1'b0, 17'h7);
      bus.inputMemoryReadDataValid = (i >= 1);
      bus.inputMemoryReadData = 8'(i);
      if (i >= 1) pushRet(1'b0, 8'(i));
      step();
    end
    idle();
    check("t6 c0GrantCount saturated", {16'd0, c0GrantCount}, 32'h0000FFFF);
    check("t6 c1GrantCount untouched", {16'd0, c1GrantCount}, 32'd0);
    step();
    check("t6 drained", ackQ.size() + retQ.size(), 32'd0);
`endif

    check("final drained", ackQ.size() + retQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
